// File: rtl/pipe_pkg.sv
// Shared definitions for the generic inter-stage pipeline register:
// occupancy states, control-bundle bit positions and default widths.
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } stage_state_e;

  // Control bundle layout, MSB first: regdest .. reg_write, aluop[1:0]
  localparam int unsigned CTRL_REGDEST   = 9;
  localparam int unsigned CTRL_JUMP      = 8;
  localparam int unsigned CTRL_BRANCH    = 7;
  localparam int unsigned CTRL_MEM_READ  = 6;
  localparam int unsigned CTRL_MEMTOREG  = 5;
  localparam int unsigned CTRL_MEM_WRITE = 4;
  localparam int unsigned CTRL_ALUSRC    = 3;
  localparam int unsigned CTRL_REG_WRITE = 2;
  localparam int unsigned CTRL_ALUOP     = 0;
  localparam int unsigned CTRL_ALUOP_W   = 2;

  localparam int unsigned DEF_CTRL_W = 10;
  localparam int unsigned DEF_DATA_W = 143;
  localparam int unsigned DEF_CNT_W  = 16;

endpackage

// File: rtl/pipe_skid_buf.sv
// Occupancy tracker plus second (skid) entry for the elastic stage register;
// in_ready is registered so there is no combinational out_ready -> in_ready path.
module pipe_skid_buf
  import pipe_pkg::*;
#(
  parameter int unsigned CTRL_W = DEF_CTRL_W,
  parameter int unsigned DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_fire,
  input  logic              out_fire,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output stage_state_e      state,
  output logic              in_ready,
  output logic              skid_valid,
  output logic [CTRL_W-1:0] skid_ctrl,
  output logic [DATA_W-1:0] skid_data
);

  stage_state_e      state_q, state_d;
  logic              in_ready_q, in_ready_d;
  logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;

  always_comb begin
    state_d     = state_q;
    skid_ctrl_d = skid_ctrl_q;
    skid_data_d = skid_data_q;
    case (state_q)
      EMPTY: if (in_fire) state_d = ONE;
      ONE: begin
        if (in_fire && !out_fire) begin
          state_d     = FULL;
          skid_ctrl_d = in_ctrl;
          skid_data_d = in_data;
        end else if (out_fire && !in_fire) begin
          state_d = EMPTY;
        end
      end
      FULL:    if (out_fire) state_d = ONE;
      default: state_d = EMPTY;
    endcase
    if (flush) state_d = EMPTY;
    // Ready for the coming cycle is decided now, from the next occupancy.
    in_ready_d = (state_d != FULL);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= EMPTY;
      in_ready_q  <= 1'b1;
      skid_ctrl_q <= '0;
      skid_data_q <= '0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      skid_ctrl_q <= skid_ctrl_d;
      skid_data_q <= skid_data_d;
    end
  end

  assign state      = state_q;
  assign in_ready   = in_ready_q;
  assign skid_valid = (state_q == FULL);
  assign skid_ctrl  = skid_ctrl_q;
  assign skid_data  = skid_data_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic elastic pipeline-stage register carrying control and data bundles
// with valid/ready handshake, flush, bubble-safe control and a stall counter.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int unsigned CTRL_W = DEF_CTRL_W,
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned SKID   = 1,
  parameter int unsigned CNT_W  = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_cnt
);

  stage_state_e      state;
  logic              in_fire, out_fire;
  logic              skid_valid;
  logic [CTRL_W-1:0] skid_ctrl;
  logic [DATA_W-1:0] skid_data;

  logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
  logic [DATA_W-1:0] main_data_q, main_data_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

  assign out_valid = (state != EMPTY);
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;

  if (SKID != 0) begin : g_skid
    pipe_skid_buf #(
      .CTRL_W(CTRL_W),
      .DATA_W(DATA_W)
    ) u_skid (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush),
      .in_fire   (in_fire),
      .out_fire  (out_fire),
      .in_ctrl   (in_ctrl),
      .in_data   (in_data),
      .state     (state),
      .in_ready  (in_ready),
      .skid_valid(skid_valid),
      .skid_ctrl (skid_ctrl),
      .skid_data (skid_data)
    );
  end else begin : g_noskid
    stage_state_e state_q, state_d;

    always_comb begin
      state_d = state_q;
      case (state_q)
        EMPTY:   if (in_fire) state_d = ONE;
        default: if (out_fire && !in_fire) state_d = EMPTY;
      endcase
      if (flush) state_d = EMPTY;
    end

    always_ff @(posedge clk) begin
      if (!rst_n) state_q <= EMPTY;
      else        state_q <= state_d;
    end

    assign state      = state_q;
    assign in_ready   = (state_q == EMPTY) || out_ready;
    assign skid_valid = 1'b0;
    assign skid_ctrl  = '0;
    assign skid_data  = '0;
  end

  // Main entry refills from the skid first to keep FIFO order.
  always_comb begin
    main_ctrl_d = main_ctrl_q;
    main_data_d = main_data_q;
    if (!flush) begin
      if (skid_valid && out_fire) begin
        main_ctrl_d = skid_ctrl;
        main_data_d = skid_data;
      end else if (in_fire && (state == EMPTY || out_fire)) begin
        main_ctrl_d = in_ctrl;
        main_data_d = in_data;
      end
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (out_valid && !out_ready && stall_cnt_q != '1)
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      main_ctrl_q <= '0;
      main_data_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      main_ctrl_q <= main_ctrl_d;
      main_data_q <= main_data_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign out_ctrl  = out_valid ? main_ctrl_q : '0;
  assign out_data  = main_data_q;
  assign stall_cnt = stall_cnt_q;

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised elastic pipeline-stage register that replaces the fixed-field inter-stage latches (IF/ID, ID/EX, EX/MEM, MEM/WB) with one generic block. It carries a control bundle and a data bundle, with a valid/ready handshake, flush, bubble-safe control zeroing and an optional 2-entry skid buffer that registers the backward ready path. It sits between any two pipeline stages; the hazard unit drives `flush` and back-pressure arrives via `out_ready`.

## Interface
- `CTRL_W`, 10: control bundle width (regdest, jump, branch, mem_read, memtoreg, mem_write, alusrc, reg_write, aluop[1:0]).
- `DATA_W`, 143: data bundle width (rs data, rt data, sign-extended imm, rs/rt/rd, instruction).
- `SKID`, 1: 1 = 2-entry skid with registered `in_ready`; 0 = single entry, combinational `in_ready`.
- `CNT_W`, 16: stall counter width.

Ports:
- `clk`  in  1  clock; all state updates on rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `flush`  in  1  kill all held entries and any same-cycle input.
- `in_valid`  in  1  upstream has an item.
- `in_ready`  out  1  stage can accept.
- `in_ctrl`  in  CTRL_W  upstream control.
- `in_data`  in  DATA_W  upstream data.
- `out_valid`  out  1  downstream item present.
- `out_ready`  in  1  downstream accepts.
- `out_ctrl`  out  CTRL_W  control; forced 0 when `out_valid`=0.
- `out_data`  out  DATA_W  data; undefined-but-stable when `out_valid`=0.
- `stall_cnt`  out  CNT_W  saturating count of back-pressured cycles.

## Operation
- Transfer in: `in_valid && in_ready`. Transfer out: `out_valid && out_ready`. Strict FIFO order; no duplication, no loss except by flush.
- SKID=1 states: EMPTY (no entry), ONE (main valid), FULL (main + skid valid).
  - EMPTY: in → ONE.
  - ONE: in & !out → FULL (input to skid); out & !in → EMPTY; in & out → ONE (main reloaded).
  - FULL: out → ONE (skid moves to main); `in_ready`=0, input not accepted.
  - `in_ready` registered: 1 iff next state ≠ FULL.
- SKID=0: states EMPTY/ONE only; `in_ready = !out_valid || out_ready` (combinational).
- Flush (sync, priority over everything except reset): next state EMPTY, both entries invalid, same-cycle input discarded; `in_ready` 1 next cycle.
- Control zeroing: `out_ctrl` = 0 whenever `out_valid`=0 (guarantees reg_write/mem_write low on bubbles). `out_data` not cleared on bubble/flush.
- `stall_cnt`: +1 each cycle `out_valid && !out_ready`; saturates at all-ones; cleared only by reset.
- Reset (`rst_n`=0 at edge): state EMPTY, `out_valid`=0, `out_ctrl`=0, `out_data`=0, skid cleared, `stall_cnt`=0, registered `in_ready`=1. Handshakes during reset cycles are ignored; reset mid-burst drops all held items.

## Timing
- Latency in→out: 1 cycle (item accepted at edge N is on `out_*` after edge N).
- Throughput: 1 item/cycle with `out_ready` held 1.
- SKID=1: `in_ready` fully registered, deasserts the cycle after the 2nd unconsumed item; no combinational `out_ready`→`in_ready` path.
- SKID=0: combinational `out_ready`→`in_ready` path; 1 item max.
- Simultaneous flush + in + out: flush wins; downstream transfer in that cycle still counts as delivered.

## Structure
- Shared package `pipe_pkg`: state enum (EMPTY, ONE, FULL); control-bit index constants (CTRL_REGDEST…CTRL_ALUOP) and default widths shared by all four stage instances.
- Sub-module `pipe_skid_buf` (skid entry + registered ready), instantiated under `generate` when SKID=1.

## Test plan
- Reset: hold `rst_n`=0 with `in_valid`=1 → `out_valid`=0, `out_ctrl`=0, `out_data`=0, `stall_cnt`=0; after release `in_ready`=1.
- Streaming: 8 items 0x1..0x8, `out_ready`=1 → out 0x1..0x8 on consecutive cycles, 1-cycle latency.
- Back-pressure (SKID=1): `out_ready`=0, push 0xA,0xB,0xC → `in_ready` drops after 0xB, 0xC held upstream; release → 0xA,0xB,0xC in order, `stall_cnt` = stalled cycles.
- Flush in FULL with `in_valid`=1 → next cycle `out_valid`=0, `out_ctrl`=0, `in_ready`=1; flushed items never appear.
- Bubble safety: `in_ctrl`=10'h3FF then idle → `out_ctrl`=0 whenever `out_valid`=0.
- Saturation (CNT_W=4): 20 stalled cycles → `stall_cnt`=4'hF, holds.
